axi_multicon_n: RTL and testbench

Parametrised AXI4 slave that merges GPIO, a prescaled 64-bit machine timer and N compare channels with per-channel interrupts. It is the multi-channel successor of the single-GPIO, single-timer multicon peripheral. It sits on a 4 KiB window of the SoC AXI interconnect, beside the boot ROM and UART. Each compare channel drives its own IRQ, and a combined IRQ feeds the core's timer interrupt input.

---
 rtl/axi_multicon_n_pkg.sv | 62 ++++++
 rtl/axi_multicon_n_mtimer_cmp.sv | 75 +++++++
 rtl/axi_multicon_n.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_multicon_n.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_multicon_n_pkg.sv
// Shared types and helpers for axi_multicon_n: register offsets, response codes,
// AXI FSM states and the offset decoder.
package axi_multicon_n_pkg;

    localparam logic [11:0] OFF_GPIO_OUT   = 12'h000;
    localparam logic [11:0] OFF_GPIO_OE    = 12'h008;
    localparam logic [11:0] OFF_GPIO_IN    = 12'h010;
    localparam logic [11:0] OFF_IRQ_STATUS = 12'h018;
    localparam logic [11:0] OFF_IRQ_ENABLE = 12'h020;
    localparam logic [11:0] OFF_MTIME      = 12'h040;
    localparam logic [11:0] OFF_PRESCALE   = 12'h048;
    localparam logic [11:0] OFF_MTIMECMP   = 12'h100;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic {R_IDLE, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    typedef enum logic [3:0] {
        REG_NONE, REG_GPIO_OUT, REG_GPIO_OE, REG_GPIO_IN, REG_IRQ_STATUS,
        REG_IRQ_ENABLE, REG_MTIME, REG_PRESCALE, REG_MTIMECMP
    } reg_e;

    typedef struct packed {
        reg_e       sel;
        logic [2:0] ch;
        logic       ok;
    } dec_t;

    // idx is the 64-bit word index addr[11:3]; n_ch bounds the compare window.
    function automatic dec_t decode(input logic [8:0] idx, input logic [8:0] n_ch);
        dec_t d;
        d.sel = REG_NONE;
        d.ch  = idx[2:0];
        d.ok  = 1'b1;
        case (idx)
            OFF_GPIO_OUT[11:3]:   d.sel = REG_GPIO_OUT;
            OFF_GPIO_OE[11:3]:    d.sel = REG_GPIO_OE;
            OFF_GPIO_IN[11:3]:    d.sel = REG_GPIO_IN;
            OFF_IRQ_STATUS[11:3]: d.sel = REG_IRQ_STATUS;
            OFF_IRQ_ENABLE[11:3]: d.sel = REG_IRQ_ENABLE;
            OFF_MTIME[11:3]:      d.sel = REG_MTIME;
            OFF_PRESCALE[11:3]:   d.sel = REG_PRESCALE;
            default: begin
                if (idx >= OFF_MTIMECMP[11:3] && idx < OFF_MTIMECMP[11:3] + n_ch)
                    d.sel = REG_MTIMECMP;
                else
                    d.ok = 1'b0;
            end
        endcase
        return d;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{strb[b]}};
        return m;
    endfunction

endpackage

// File: rtl/axi_multicon_n_mtimer_cmp.sv
// Prescaled 64-bit machine timer with N compare channels and sticky,
// maskable per-channel interrupt status.
module mtimer_cmp
    import axi_multicon_n_pkg::*;
#(
    parameter int N_TIMERS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  reg_e                     wr_sel,
    input  logic [2:0]               wr_ch,
    input  logic [63:0]              wr_data,
    input  logic [7:0]               wr_strb,
    output logic [63:0]              mtime,
    output logic [31:0]              prescale,
    output logic [N_TIMERS-1:0][63:0] mtimecmp,
    output logic [N_TIMERS-1:0]      irq_status,
    output logic [N_TIMERS-1:0]      irq_enable,
    output logic [N_TIMERS-1:0]      timer_irq
);
    logic [63:0]         wmask;
    logic [31:0]         pcnt;
    logic                wr_prescale;
    logic                tick;
    logic [N_TIMERS-1:0] cmp_hit;
    logic [N_TIMERS-1:0] w1c;

    assign wmask       = byte_mask(wr_strb);
    assign wr_prescale = wr_en && (wr_sel == REG_PRESCALE);
    assign tick        = (pcnt == prescale) && !wr_prescale;
    assign w1c         = (wr_en && wr_sel == REG_IRQ_STATUS) ?
                         (wr_data[N_TIMERS-1:0] & wmask[N_TIMERS-1:0]) : '0;
    assign timer_irq   = irq_status & irq_enable;

    always_comb begin
        cmp_hit = '0;
        for (int i = 0; i < N_TIMERS; i++) cmp_hit[i] = (mtime >= mtimecmp[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            prescale   <= '0;
            mtime      <= '0;
            mtimecmp   <= '1;
            irq_status <= '0;
            irq_enable <= '0;
        end else begin
            if (wr_prescale) begin
                prescale <= (prescale & ~wmask[31:0]) | (wr_data[31:0] & wmask[31:0]);
                pcnt     <= '0;
            end else if (pcnt == prescale) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 32'd1;
            end
            // Software writes to MTIME take priority over the prescaled tick.
            if (wr_en && wr_sel == REG_MTIME)
                mtime <= (mtime & ~wmask) | (wr_data & wmask);
            else if (tick)
                mtime <= mtime + 64'd1;
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr_en && wr_sel == REG_MTIMECMP && wr_ch == i[2:0])
                    mtimecmp[i] <= (mtimecmp[i] & ~wmask) | (wr_data & wmask);
            end
            if (wr_en && wr_sel == REG_IRQ_ENABLE)
                irq_enable <= (irq_enable & ~wmask[N_TIMERS-1:0]) |
                              (wr_data[N_TIMERS-1:0] & wmask[N_TIMERS-1:0]);
            // A live compare match outranks a simultaneous clear.
            irq_status <= (irq_status & ~w1c) | cmp_hit;
        end
    end

endmodule

// File: rtl/axi_multicon_n.sv
// AXI4 slave exposing GPIO, a prescaled machine timer and N compare channels.
// Valid/ready: a valid stays high with stable payload until its ready; a beat moves on valid && ready.
module axi_multicon_n
    import axi_multicon_n_pkg::*;
#(
    parameter int ID_WIDTH = 6,
    parameter int GPIO_W   = 8,
    parameter int N_TIMERS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [11:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [11:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    input  logic [GPIO_W-1:0]   i_gpio_in,
    output logic [GPIO_W-1:0]   o_gpio_out,
    output logic [GPIO_W-1:0]   o_gpio_oe,
    output logic [N_TIMERS-1:0] o_timer_irq,
    output logic                o_irq
);
    localparam logic [8:0] N_CH = 9'(N_TIMERS);

    rd_state_e r_state, r_state_nxt;
    wr_state_e w_state, w_state_nxt;
    logic [7:0]  r_len, r_beat;
    logic [1:0]  r_burst, w_burst;
    logic [11:0] r_addr, r_addr_adv, w_addr, w_addr_adv;
    logic [8:0]  rd_idx;
    dec_t        rd_dec, w_dec;
    logic [63:0] rd_val, gpio_mask;
    logic        r_last_beat, w_beat, w_err, wr_en;
    logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;
    logic [63:0]              mtime;
    logic [31:0]              prescale;
    logic [N_TIMERS-1:0][63:0] mtimecmp;
    logic [N_TIMERS-1:0]      irq_status, irq_enable;
    logic                     unused_bits;

    assign unused_bits = ^{i_awsize, i_arsize, i_awlen, gpio_mask};

    // ---------------- read channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    assign r_last_beat = (r_beat == r_len);

    always_comb begin
        r_state_nxt = r_state;
        o_arready   = 1'b0;
        o_rvalid    = 1'b0;
        case (r_state)
            R_IDLE: begin
                o_arready = 1'b1;
                if (i_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                o_rvalid = 1'b1;
                if (i_rready && r_last_beat) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign o_rlast    = o_rvalid && r_last_beat;
    assign r_addr_adv = (r_burst == BURST_FIXED) ? r_addr : r_addr + 12'd8;
    // One decode/mux serves both the first beat (from AR) and follow-on beats.
    assign rd_idx     = (r_state == R_IDLE) ? i_araddr[11:3] : r_addr_adv[11:3];
    assign rd_dec     = decode(rd_idx, N_CH);

    always_comb begin
        rd_val = '0;
        case (rd_dec.sel)
            REG_GPIO_OUT:   rd_val[GPIO_W-1:0]   = o_gpio_out;
            REG_GPIO_OE:    rd_val[GPIO_W-1:0]   = o_gpio_oe;
            REG_GPIO_IN:    rd_val[GPIO_W-1:0]   = gpio_sync2;
            REG_IRQ_STATUS: rd_val[N_TIMERS-1:0] = irq_status;
            REG_IRQ_ENABLE: rd_val[N_TIMERS-1:0] = irq_enable;
            REG_MTIME:      rd_val               = mtime;
            REG_PRESCALE:   rd_val[31:0]         = prescale;
            REG_MTIMECMP: begin
                for (int i = 0; i < N_TIMERS; i++)
                    if (rd_dec.ch == i[2:0]) rd_val = mtimecmp[i];
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rid   <= '0;
            o_rdata <= '0;
            o_rresp <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
        end else if (o_arready && i_arvalid) begin
            o_rid   <= i_arid;
            o_rdata <= rd_val;
            o_rresp <= rd_dec.ok ? RESP_OKAY : RESP_SLVERR;
            r_addr  <= i_araddr;
            r_len   <= i_arlen;
            r_beat  <= '0;
            r_burst <= i_arburst;
        end else if (o_rvalid && i_rready && !r_last_beat) begin
            o_rdata <= rd_val;
            o_rresp <= rd_dec.ok ? RESP_OKAY : RESP_SLVERR;
            r_addr  <= r_addr_adv;
            r_beat  <= r_beat + 8'd1;
        end
    end

    // ---------------- write channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        o_awready   = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                o_awready = 1'b1;
                if (i_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && i_wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign w_dec      = decode(w_addr[11:3], N_CH);
    assign w_addr_adv = (w_burst == BURST_FIXED) ? w_addr : w_addr + 12'd8;
    assign w_beat     = o_wready && i_wvalid;
    assign wr_en      = w_beat && w_dec.ok;
    assign gpio_mask  = byte_mask(i_wstrb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bid   <= '0;
            o_bresp <= RESP_OKAY;
            w_addr  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else if (o_awready && i_awvalid) begin
            o_bid   <= i_awid;
            w_addr  <= i_awaddr;
            w_burst <= i_awburst;
            w_err   <= 1'b0;
        end else if (w_beat) begin
            w_addr <= w_addr_adv;
            w_err  <= w_err || !w_dec.ok;
            if (i_wlast) o_bresp <= (w_err || !w_dec.ok) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ---------------- GPIO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
            o_gpio_out <= '0;
            o_gpio_oe  <= '0;
        end else begin
            gpio_sync1 <= i_gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (wr_en && w_dec.sel == REG_GPIO_OUT)
                o_gpio_out <= (o_gpio_out & ~gpio_mask[GPIO_W-1:0]) |
                              (i_wdata[GPIO_W-1:0] & gpio_mask[GPIO_W-1:0]);
            if (wr_en && w_dec.sel == REG_GPIO_OE)
                o_gpio_oe <= (o_gpio_oe & ~gpio_mask[GPIO_W-1:0]) |
                             (i_wdata[GPIO_W-1:0] & gpio_mask[GPIO_W-1:0]);
        end
    end

    mtimer_cmp #(.N_TIMERS(N_TIMERS)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_sel     (w_dec.sel),
        .wr_ch      (w_dec.ch),
        .wr_data    (i_wdata),
        .wr_strb    (i_wstrb),
        .mtime      (mtime),
        .prescale   (prescale),
        .mtimecmp   (mtimecmp),
        .irq_status (irq_status),
        .irq_enable (irq_enable),
        .timer_irq  (o_timer_irq)
    );

    assign o_irq = |o_timer_irq;

endmodule

// File: tb/tb_axi_multicon_n.sv
// Directed bench for axi_multicon_n (ID_WIDTH=6, GPIO_W=8, N_TIMERS=2).
module tb_axi_multicon_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  i_awid, i_arid, o_bid, o_rid;
    logic [11:0] i_awaddr, i_araddr;
    logic [7:0]  i_awlen, i_arlen, i_wstrb;
    logic [2:0]  i_awsize, i_arsize;
    logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
    logic        i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
    logic        i_arvalid, o_arready, o_rlast, o_rvalid, i_rready, o_irq;
    logic [63:0] i_wdata, o_rdata;
    logic [7:0]  i_gpio_in, o_gpio_out, o_gpio_oe;
    logic [1:0]  o_timer_irq;

    int tests = 0;
    int failed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    axi_multicon_n #(.ID_WIDTH(6), .GPIO_W(8), .N_TIMERS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
        .i_bready(i_bready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
        .o_arready(o_arready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .i_gpio_in(i_gpio_in), .o_gpio_out(o_gpio_out), .o_gpio_oe(o_gpio_oe),
        .o_timer_irq(o_timer_irq), .o_irq(o_irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Single AW, then len+1 W beats carrying data, data+1, ...
    task automatic axi_write(input logic [11:0] addr, input logic [7:0] len, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        i_awid = 6'h15; i_awaddr = addr; i_awlen = len; i_awburst = 2'b01; i_awsize = 3'd3;
        i_awvalid = 1'b1;
        n = 0;
        while (!o_awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        i_awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            i_wdata = data + 64'(k); i_wstrb = strb; i_wlast = (k == int'(len)); i_wvalid = 1'b1;
            n = 0;
            while (!o_wready && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        check("wr_bvalid", o_bvalid, 1'b1);
        check("wr_bresp", o_bresp, exp_resp);
        check("wr_bid", o_bid, 6'h15);
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    // Expected beat data is taken from exp_q; optional 3-cycle rready stall on one beat.
    task automatic axi_read(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] exp_resp, input int stall_beat);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        i_arid = 6'h2A; i_araddr = addr; i_arlen = len; i_arburst = burst; i_arsize = 3'd3;
        i_arvalid = 1'b1;
        n = 0;
        while (!o_arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        i_arvalid = 1'b0;
        check("rd_latency", o_rvalid, 1'b1);
        i_rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!o_rvalid && n < 20) begin @(negedge clk); n++; end
            exp = 64'hBAD0_BAD0_BAD0_BAD0;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            if (b == stall_beat) begin
                i_rready = 1'b0;
                repeat (3) @(negedge clk);
                check($sformatf("rd_stall_valid[%0d]", b), o_rvalid, 1'b1);
                i_rready = 1'b1;
            end
            check($sformatf("rd_data[%0d]", b), o_rdata, exp);
            check($sformatf("rd_resp[%0d]", b), o_rresp, exp_resp);
            check($sformatf("rd_last[%0d]", b), o_rlast, (b == int'(len)));
            check($sformatf("rd_id[%0d]", b), o_rid, 6'h2A);
            @(negedge clk);
        end
        i_rready = 1'b0;
        check("rd_done", o_rvalid, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
        i_rready = 1'b0; i_gpio_in = 8'h5A;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_arready", o_arready, 1'b1);
        check("rst_awready", o_awready, 1'b1);
        check("rst_wready", o_wready, 1'b0);
        check("rst_rvalid", o_rvalid, 1'b0);
        check("rst_bvalid", o_bvalid, 1'b0);
        check("rst_rdata", o_rdata, 64'h0);
        check("rst_gpio_out", o_gpio_out, 8'h00);
        check("rst_irq", o_irq, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTIMECMP[0] reset value
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        axi_read(12'h100, 8'd0, 2'b01, 2'b00, -1);

        // Byte strobes on GPIO_OUT, then GPIO_OE
        axi_write(12'h000, 8'd0, 64'hA5, 8'h01, 2'b00);
        check("gpio_out_a5", o_gpio_out, 8'hA5);
        axi_write(12'h000, 8'd0, 64'hFF, 8'h00, 2'b00);
        check("gpio_out_nostrb", o_gpio_out, 8'hA5);
        axi_write(12'h008, 8'd0, 64'h3C, 8'hFF, 2'b00);
        check("gpio_oe_3c", o_gpio_oe, 8'h3C);

        // INCR burst over the GPIO block with a mid-burst stall
        exp_q.push_back(64'hA5); exp_q.push_back(64'h3C);
        exp_q.push_back(64'h5A); exp_q.push_back(64'h0);
        axi_read(12'h000, 8'd3, 2'b01, 2'b00, 1);

        // FIXED burst stays on GPIO_OE
        exp_q.push_back(64'h3C); exp_q.push_back(64'h3C);
        axi_read(12'h008, 8'd1, 2'b00, 2'b00, -1);

        // Unmapped accesses
        axi_write(12'h200, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10);
        check("unmapped_gpio_out", o_gpio_out, 8'hA5);
        check("unmapped_gpio_oe", o_gpio_oe, 8'h3C);
        exp_q.push_back(64'h0);
        axi_read(12'h110, 8'd0, 2'b01, 2'b10, -1);

        // Two-beat INCR write: GPIO_OUT then GPIO_OE
        axi_write(12'h000, 8'd1, 64'h11, 8'hFF, 2'b00);
        check("burst_wr_out", o_gpio_out, 8'h11);
        check("burst_wr_oe", o_gpio_oe, 8'h12);

        // Timer: PRESCALE=3, MTIME=0, enable ch1, MTIMECMP[1]=5
        axi_write(12'h048, 8'd0, 64'd3, 8'hFF, 2'b00);
        axi_write(12'h040, 8'd0, 64'd0, 8'hFF, 2'b00);
        axi_write(12'h020, 8'd0, 64'd2, 8'hFF, 2'b00);
        axi_write(12'h108, 8'd0, 64'd5, 8'hFF, 2'b00);
        check("irq_not_yet", o_timer_irq, 2'b00);
        n = 0;
        while (!o_irq && n < 200) begin @(negedge clk); n++; end
        check("irq_not_early", (n >= 4), 1'b1);
        check("timer_irq_ch1", o_timer_irq, 2'b10);
        check("irq_or", o_irq, 1'b1);
        axi_write(12'h018, 8'd0, 64'd2, 8'hFF, 2'b00);
        exp_q.push_back(64'd2);
        axi_read(12'h018, 8'd0, 2'b01, 2'b00, -1);
        check("w1c_set_wins", o_irq, 1'b1);
        axi_write(12'h108, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00);
        axi_write(12'h018, 8'd0, 64'd2, 8'hFF, 2'b00);
        check("w1c_cleared", o_timer_irq, 2'b00);
        exp_q.push_back(64'd0);
        axi_read(12'h018, 8'd0, 2'b01, 2'b00, -1);

        // Reset in the middle of a 4-beat read
        @(negedge clk);
        i_arid = 6'h2A; i_araddr = 12'h000; i_arlen = 8'd3; i_arburst = 2'b01; i_arvalid = 1'b1;
        @(negedge clk);
        i_arvalid = 1'b0; i_rready = 1'b1;
        repeat (2) @(negedge clk);
        i_rready = 1'b0;
        check("midburst_rvalid", o_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_rvalid", o_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_arready", o_arready, 1'b1);
        check("post_rst_gpio_out", o_gpio_out, 8'h00);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        axi_read(12'h108, 8'd0, 2'b01, 2'b00, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
